// File: rtl/seconds_pkg.sv
// Shared constants for the seconds timebase: counter moduli, pad map and static output enables.
package seconds_pkg;

   localparam int unsigned SEC_MOD = 60;
   localparam int unsigned MIN_MOD = 60;

   localparam int unsigned IO_W       = 38;
   localparam int unsigned PIN_CHK_LO = 0;
   localparam int unsigned PIN_SEC_LO = 8;
   localparam int unsigned PIN_MIN_LO = 14;
   localparam int unsigned PIN_TICK   = 20;

   // Drive pins [1:0] and [20:8]; pins 3 and 7:2 stay with mgmt/UART.
   localparam logic [IO_W-1:0] OEB_MASK = ~38'h00_001F_FF03;

   function automatic logic at_last(input logic [5:0] v, input int unsigned modulus);
      return v == 6'(modulus - 1);
   endfunction

endpackage

// File: rtl/seconds_timebase_tick_prescaler.sv
// Programmable prescaler: divides the core clock down to one advance pulse per div_eff enabled cycles.
module tick_prescaler #(
   parameter int unsigned CLK_HZ = 40_000_000,
   parameter int unsigned DIV_W  = 26
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_i,
   input  logic             clear_i,
   input  logic             div_we_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             adv_o,
   output logic             tick_o
);

   localparam logic [DIV_W-1:0] DIV_RST = CLK_HZ[DIV_W-1:0];
   localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] pre_q;
   logic [DIV_W-1:0] div_eff;
   logic             pre_last;
   logic             tick_q;

   // A divisor of 0 behaves as 1 so the counter can never run away past the terminal value.
   assign div_eff  = (div_q == '0) ? DIV_ONE : div_q;
   assign pre_last = (pre_q == div_eff - DIV_ONE);

   // Clear and divisor writes both restart the count and swallow a coincident tick.
   assign adv_o  = run_i & pre_last & ~clear_i & ~div_we_i;
   assign tick_o = tick_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q  <= DIV_RST;
         pre_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         if (div_we_i) div_q <= div_i;
         if (clear_i || div_we_i) begin
            pre_q <= '0;
         end else if (run_i) begin
            pre_q <= pre_last ? '0 : pre_q + DIV_ONE;
         end
         tick_q <= adv_o;
      end
   end

endmodule

// File: rtl/seconds_timebase.sv
// Seconds/minutes timebase for the user project; counts ticks mod 60 and maps them onto the pads.
module seconds_timebase
   import seconds_pkg::*;
#(
   parameter int unsigned CLK_HZ = 40_000_000,
   parameter int unsigned DIV_W  = 26
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             run_i,
   input  logic             clear_i,
   input  logic             div_we_i,
   input  logic [DIV_W-1:0] div_i,
   output logic [5:0]       sec_o,
   output logic [5:0]       min_o,
   output logic             tick_o,
   output logic             wrap_o,
   output logic [37:0]      io_out,
   output logic [37:0]      io_oeb
);

   logic       adv;
   logic [5:0] sec_q, sec_d;
   logic [5:0] min_q, min_d;
   logic       wrap_q, wrap_d;

   tick_prescaler #(
      .CLK_HZ (CLK_HZ),
      .DIV_W  (DIV_W)
   ) u_prescaler (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .run_i    (run_i),
      .clear_i  (clear_i),
      .div_we_i (div_we_i),
      .div_i    (div_i),
      .adv_o    (adv),
      .tick_o   (tick_o)
   );

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path can infer a latch.
      sec_d  = sec_q;
      min_d  = min_q;
      wrap_d = 1'b0;
      if (clear_i) begin
         sec_d = '0;
         min_d = '0;
      end else if (adv) begin
         if (at_last(sec_q, SEC_MOD)) begin
            sec_d = '0;
            if (at_last(min_q, MIN_MOD)) begin
               min_d  = '0;
               wrap_d = 1'b1;
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sec_q  <= '0;
         min_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         sec_q  <= sec_d;
         min_q  <= min_d;
         wrap_q <= wrap_d;
      end
   end

   assign sec_o  = sec_q;
   assign min_o  = min_q;
   assign wrap_o = wrap_q;

   // Pads are driven straight from registers so they move on the same edge as sec_o/tick_o.
   always_comb begin
      io_out                      = '0;
      io_out[PIN_CHK_LO +: 2]     = sec_q[1:0];
      io_out[PIN_SEC_LO +: 6]     = sec_q;
      io_out[PIN_MIN_LO +: 6]     = min_q;
      io_out[PIN_TICK]            = tick_o;
   end

   assign io_oeb = OEB_MASK;

endmodule

// File: tb/tb_seconds_timebase.sv
// Directed bench for seconds_timebase: vector table plus hand-written multi-cycle sequences.
module tb_seconds_timebase;

   localparam int unsigned DIV_W   = 26;
   localparam int unsigned CLK_HZ  = 7;
   localparam logic [37:0] OEB_EXP = 38'h3F_FFE0_00FC;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             run = 1'b0;
   logic             clr = 1'b0;
   logic             we  = 1'b0;
   logic [DIV_W-1:0] div = '0;
   logic [5:0]       sec_o, min_o;
   logic             tick_o, wrap_o;
   logic [37:0]      io_out, io_oeb;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic             run;
      logic             clr;
      logic             we;
      logic [DIV_W-1:0] div;
      int               es;
      int               em;
      logic             et;
      logic             ew;
   } vec_t;

   vec_t vecs[$];

   seconds_timebase #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .run_i    (run),
      .clear_i  (clr),
      .div_we_i (we),
      .div_i    (div),
      .sec_o    (sec_o),
      .min_o    (min_o),
      .tick_o   (tick_o),
      .wrap_o   (wrap_o),
      .io_out   (io_out),
      .io_oeb   (io_oeb)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic c, input logic w, input int d,
                               input int es, input int em, input logic et, input logic ew);
      vec_t v;
      v.run = r; v.clr = c; v.we = w; v.div = DIV_W'(d);
      v.es = es; v.em = em; v.et = et; v.ew = ew;
      return v;
   endfunction

   function automatic logic [37:0] exp_io(input int s, input int m, input logic t);
      logic [37:0] v;
      v        = '0;
      v[1:0]   = 2'(s);
      v[13:8]  = 6'(s);
      v[19:14] = 6'(m);
      v[20]    = t;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input int es, input int em,
                             input logic et, input logic ew);
      check({name, ".sec"},  64'(sec_o),  64'(es));
      check({name, ".min"},  64'(min_o),  64'(em));
      check({name, ".tick"}, 64'(tick_o), 64'(et));
      check({name, ".wrap"}, 64'(wrap_o), 64'(ew));
      check({name, ".io"},   64'(io_out), 64'(exp_io(es, em, et)));
      check({name, ".oeb"},  64'(io_oeb), 64'(OEB_EXP));
   endtask

   // Inputs change 1 ns after an edge; outputs are sampled 1 ns after the next edge.
   task automatic apply(input logic r, input logic c, input logic w, input int d);
      run = r; clr = c; we = w; div = DIV_W'(d);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int wraps;
      int es, em;

      // div=4 then run: tick every 4th edge, pads [1:0] step 0,1,2,3,0
      vecs.push_back(mk(0,0,1,4, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,1,0));
      vecs.push_back(mk(1,0,0,0, 1,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,0,0));
      vecs.push_back(mk(1,0,0,0, 2,0,1,0));
      vecs.push_back(mk(1,0,0,0, 2,0,0,0));
      vecs.push_back(mk(1,0,0,0, 2,0,0,0));
      vecs.push_back(mk(1,0,0,0, 2,0,0,0));
      vecs.push_back(mk(1,0,0,0, 3,0,1,0));
      vecs.push_back(mk(1,0,0,0, 3,0,0,0));
      vecs.push_back(mk(1,0,0,0, 3,0,0,0));
      vecs.push_back(mk(1,0,0,0, 3,0,0,0));
      vecs.push_back(mk(1,0,0,0, 4,0,1,0));
      // run low holds everything
      vecs.push_back(mk(0,0,0,0, 4,0,0,0));
      // div=0 behaves as 1; the write edge itself never ticks
      vecs.push_back(mk(1,0,1,0, 4,0,0,0));
      vecs.push_back(mk(1,0,0,0, 5,0,1,0));
      vecs.push_back(mk(1,0,0,0, 6,0,1,0));
      vecs.push_back(mk(1,0,0,0, 7,0,1,0));
      // clear on a tick edge wins over the tick
      vecs.push_back(mk(1,1,0,0, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,1,0));
      // div=4, then clear+write div=3 on the terminal edge
      vecs.push_back(mk(1,0,1,4, 1,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,0,0));
      vecs.push_back(mk(1,1,1,3, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,1,0));

      // Reset state
      apply(0, 0, 0, 0);
      apply(0, 0, 0, 0);
      check_outs("reset", 0, 0, 0, 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         apply(vecs[i].run, vecs[i].clr, vecs[i].we, int'(vecs[i].div));
         check_outs($sformatf("vec%0d", i), vecs[i].es, vecs[i].em, vecs[i].et, vecs[i].ew);
      end

      // Full hour at div=1: 3600 ticks, exactly one wrap on 59:59 -> 00:00
      apply(0, 1, 1, 1);
      check_outs("hour_start", 0, 0, 0, 0);
      wraps = 0;
      for (int n = 1; n <= 3600; n++) begin
         apply(1, 0, 0, 0);
         es = n % 60;
         em = (n / 60) % 60;
         if (wrap_o === 1'b1) wraps++;
         check_outs($sformatf("hour%0d", n), es, em, 1'b1, (n == 3600));
      end
      check("hour_wraps", 64'(wraps), 64'd1);

      // div=10: run_i drops once pre has counted to 6, so 4 enabled edges remain after it returns
      apply(0, 1, 1, 10);
      for (int n = 1; n <= 10; n++) begin
         apply(1, 0, 0, 0);
         check_outs($sformatf("d10_%0d", n), (n == 10) ? 1 : 0, 0, (n == 10), 0);
      end
      for (int n = 1; n <= 6; n++) begin
         apply(1, 0, 0, 0);
         check_outs($sformatf("d10_pre%0d", n), 1, 0, 0, 0);
      end
      for (int n = 1; n <= 20; n++) begin
         apply(0, 0, 0, 0);
         check_outs($sformatf("hold%0d", n), 1, 0, 0, 0);
      end
      for (int n = 1; n <= 4; n++) begin
         apply(1, 0, 0, 0);
         check_outs($sformatf("resume%0d", n), (n == 4) ? 2 : 1, 0, (n == 4), 0);
      end

      // Reset at sec=37 with a divisor write in flight: divisor returns to CLK_HZ
      apply(0, 1, 1, 1);
      for (int n = 1; n <= 37; n++) apply(1, 0, 0, 0);
      check_outs("at37", 37, 0, 1, 0);
      rst = 1'b1;
      apply(1, 0, 1, 2);
      check_outs("rst37", 0, 0, 0, 0);
      rst = 1'b0;
      for (int n = 1; n <= int'(CLK_HZ); n++) begin
         apply(1, 0, 0, 0);
         check_outs($sformatf("post_rst%0d", n), (n == int'(CLK_HZ)) ? 1 : 0, 0,
                    (n == int'(CLK_HZ)), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
